hazard_scoreboard: RTL and testbench

// Parametrised successor to the two-stage load-use hazard detector. Tracks the destination of every
// in-flight instruction across DEPTH post-decode stages (stage 0 = EX), and produces the decode-stage

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_operand_match.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the hazard scoreboard
package hazard_pkg;

  localparam int DEF_NREG   = 16;
  localparam int DEF_DEPTH  = 3;
  // Entry rd field is sized for the largest supported register file (256)
  // so the struct stays parameter-independent; narrower indices zero-extend.
  localparam int MAX_REG_W  = 8;
  localparam int FWD_NONE   = 0;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [MAX_REG_W-1:0] rd;
    logic                 is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_operand_match.sv
// rtl/hazard_operand_match.sv - match one source operand against all tracked stages
// Ports:
//   src_en, id_valid, src : operand read request from decode
//   entries               : in-flight destination state, index 0 = EX (youngest)
//   hit, stage, is_load   : youngest matching stage and whether it is a load
module hazard_operand_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int REG_W    = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter int FWD_W    = 2
) (
  input  logic             src_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src,
  input  sb_entry_t        entries [DEPTH],
  output logic             hit,
  output logic [FWD_W-1:0] stage,
  output logic             is_load
);

  logic src_live;

  assign src_live = src_en && id_valid && !(ZERO_REG && (src == '0));

  // Scan oldest to youngest so the youngest (lowest index) match overwrites.
  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    is_load = 1'b0;
    if (src_live) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (entries[k].valid && entries[k].wr_en &&
            (entries[k].rd == MAX_REG_W'(src))) begin
          hit     = 1'b1;
          stage   = FWD_W'(k);
          is_load = entries[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker with stall and forward selects
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   id_*                        : decode-stage instruction fields
//   flush                       : kill decode instruction (bubble)
//   ext_stall                   : freeze all tracked stages
//   stall                       : hold IF/ID, bubble into ID/EX
//   fwd_rs_sel, fwd_rt_sel      : 0 = regfile, k+1 = forward from stage k
//   stall_cnt                   : saturating hazard-stall cycle count
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREG       = DEF_NREG,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int LOAD_STAGE = 1,
  parameter  bit ZERO_REG   = 1'b1,
  localparam int REG_W      = $clog2(NREG),
  localparam int FWD_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs_en,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rt_en,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             stall,
  output logic [FWD_W-1:0] fwd_rs_sel,
  output logic [FWD_W-1:0] fwd_rt_sel,
  output logic [15:0]      stall_cnt
);

  sb_entry_t        entries [DEPTH];
  sb_entry_t        new_entry;
  logic             rs_hit, rt_hit, rs_load, rt_load;
  logic [FWD_W-1:0] rs_stage, rt_stage;
  logic             rs_haz, rt_haz, hazard_stall, accept;

  hazard_operand_match #(
    .DEPTH(DEPTH), .REG_W(REG_W), .ZERO_REG(ZERO_REG), .FWD_W(FWD_W)
  ) u_rs_match (
    .src_en(id_rs_en), .id_valid(id_valid), .src(id_rs), .entries(entries),
    .hit(rs_hit), .stage(rs_stage), .is_load(rs_load)
  );

  hazard_operand_match #(
    .DEPTH(DEPTH), .REG_W(REG_W), .ZERO_REG(ZERO_REG), .FWD_W(FWD_W)
  ) u_rt_match (
    .src_en(id_rt_en), .id_valid(id_valid), .src(id_rt), .entries(entries),
    .hit(rt_hit), .stage(rt_stage), .is_load(rt_load)
  );

  // A load's data only exists from LOAD_STAGE's output onward; a younger
  // load match cannot be forwarded yet.
  assign rs_haz       = rs_hit && rs_load && (rs_stage < FWD_W'(LOAD_STAGE));
  assign rt_haz       = rt_hit && rt_load && (rt_stage < FWD_W'(LOAD_STAGE));
  assign hazard_stall = rs_haz || rt_haz;
  assign stall        = hazard_stall || ext_stall;
  assign accept       = id_valid && !hazard_stall && !flush;

  always_comb begin
    fwd_rs_sel = FWD_W'(FWD_NONE);
    fwd_rt_sel = FWD_W'(FWD_NONE);
    if (!hazard_stall) begin
      if (rs_hit) fwd_rs_sel = rs_stage + FWD_W'(1);
      if (rt_hit) fwd_rt_sel = rt_stage + FWD_W'(1);
    end
  end

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.wr_en   = id_wr_en;
    new_entry.rd      = MAX_REG_W'(id_rd);
    new_entry.is_load = id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) entries[k] <= '0;
      stall_cnt <= '0;
    end else if (!ext_stall) begin
      for (int k = 1; k < DEPTH; k++) entries[k] <= entries[k-1];
      entries[0] <= accept ? new_entry : '0;
      if (hazard_stall && !flush && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_rs_en, id_rt_en, id_wr_en, id_is_load, flush, ext_stall;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [15:0] stall_cnt;

  typedef struct {
    logic        stall;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_en(id_rs_en), .id_rs(id_rs),
    .id_rt_en(id_rt_en), .id_rt(id_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt)
  );

  task automatic drive(input logic v, input logic rse, input int rsi, input logic rte,
                       input int rti, input logic we, input int rdi, input logic ld,
                       input logic fl, input logic es);
    id_valid = v; id_rs_en = rse; id_rs = 4'(rsi); id_rt_en = rte; id_rt = 4'(rti);
    id_wr_en = we; id_rd = 4'(rdi); id_is_load = ld; flush = fl; ext_stall = es;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_exp(input logic s, input int rs, input int rt, input int cnt);
    exp_t x;
    x.stall = s; x.rs = 2'(rs); x.rt = 2'(rt); x.cnt = 16'(cnt);
    sb_q.push_back(x);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      case (i)
        0: begin idle();                               push_exp(0, 0, 0, 0); end
        default: begin drive(1, 1, 3, 1, 3, 0, 0, 0, 0, 0); push_exp(0, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      total++; if (stall !== e.stall) begin bad++; $display("FAIL reset.%0d stall got=%b want=%b", i, stall, e.stall); end
      total++; if (fwd_rs_sel !== e.rs) begin bad++; $display("FAIL reset.%0d rs_sel got=%0d want=%0d", i, fwd_rs_sel, e.rs); end
      total++; if (fwd_rt_sel !== e.rt) begin bad++; $display("FAIL reset.%0d rt_sel got=%0d want=%0d", i, fwd_rt_sel, e.rt); end
      total++; if (stall_cnt !== e.cnt) begin bad++; $display("FAIL reset.%0d cnt got=%0d want=%0d", i, stall_cnt, e.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forward();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin drive(1, 1, 1, 1, 2, 1, 3, 0, 0, 0); push_exp(0, 0, 0, 0); end  // add r3
        1: begin drive(1, 1, 3, 1, 1, 1, 5, 0, 0, 0); push_exp(0, 1, 0, 0); end  // r5=r3+r1
        2: begin drive(1, 1, 3, 0, 0, 1, 9, 0, 0, 0); push_exp(0, 2, 0, 0); end  // r3 at MEM
        3: begin drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0); push_exp(0, 0, 3, 0); end  // r3 at WB
        default: begin drive(1, 1, 3, 1, 3, 0, 0, 0, 0, 0); push_exp(0, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      total++; if (stall !== e.stall) begin bad++; $display("FAIL fwd.%0d stall got=%b want=%b", i, stall, e.stall); end
      total++; if (fwd_rs_sel !== e.rs) begin bad++; $display("FAIL fwd.%0d rs_sel got=%0d want=%0d", i, fwd_rs_sel, e.rs); end
      total++; if (fwd_rt_sel !== e.rt) begin bad++; $display("FAIL fwd.%0d rt_sel got=%0d want=%0d", i, fwd_rt_sel, e.rt); end
      total++; if (stall_cnt !== e.cnt) begin bad++; $display("FAIL fwd.%0d cnt got=%0d want=%0d", i, stall_cnt, e.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 1, 1, 0, 0, 1, 4, 1, 0, 0); push_exp(0, 0, 0, 0); end  // lw r4
        1: begin drive(1, 1, 4, 1, 4, 1, 6, 0, 0, 0); push_exp(1, 0, 0, 0); end  // r6=r4+r4 stalls
        2: begin drive(1, 1, 4, 1, 4, 1, 6, 0, 0, 0); push_exp(0, 2, 2, 1); end  // retry forwards
        default: begin idle();                        push_exp(0, 0, 0, 1); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      total++; if (stall !== e.stall) begin bad++; $display("FAIL load.%0d stall got=%b want=%b", i, stall, e.stall); end
      total++; if (fwd_rs_sel !== e.rs) begin bad++; $display("FAIL load.%0d rs_sel got=%0d want=%0d", i, fwd_rs_sel, e.rs); end
      total++; if (fwd_rt_sel !== e.rt) begin bad++; $display("FAIL load.%0d rt_sel got=%0d want=%0d", i, fwd_rt_sel, e.rt); end
      total++; if (stall_cnt !== e.cnt) begin bad++; $display("FAIL load.%0d cnt got=%0d want=%0d", i, stall_cnt, e.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); push_exp(0, 0, 0, 0); end
        1: begin drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); push_exp(0, 0, 0, 0); end
        default: begin drive(1, 1, 2, 1, 2, 0, 0, 0, 0, 0); push_exp(0, 1, 1, 0); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      total++; if (stall !== e.stall) begin bad++; $display("FAIL b2b.%0d stall got=%b want=%b", i, stall, e.stall); end
      total++; if (fwd_rs_sel !== e.rs) begin bad++; $display("FAIL b2b.%0d rs_sel got=%0d want=%0d", i, fwd_rs_sel, e.rs); end
      total++; if (fwd_rt_sel !== e.rt) begin bad++; $display("FAIL b2b.%0d rt_sel got=%0d want=%0d", i, fwd_rt_sel, e.rt); end
      total++; if (stall_cnt !== e.cnt) begin bad++; $display("FAIL b2b.%0d cnt got=%0d want=%0d", i, stall_cnt, e.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_and_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); push_exp(0, 0, 0, 0); end  // lw r0
        1: begin drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0); push_exp(0, 0, 0, 0); end  // read r0
        2: begin drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0); push_exp(0, 0, 0, 0); end  // lw r7
        3: begin drive(1, 1, 7, 0, 0, 1, 8, 0, 1, 0); push_exp(1, 0, 0, 0); end  // use + flush
        default: begin drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); push_exp(0, 2, 0, 0); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      total++; if (stall !== e.stall) begin bad++; $display("FAIL zf.%0d stall got=%b want=%b", i, stall, e.stall); end
      total++; if (fwd_rs_sel !== e.rs) begin bad++; $display("FAIL zf.%0d rs_sel got=%0d want=%0d", i, fwd_rs_sel, e.rs); end
      total++; if (fwd_rt_sel !== e.rt) begin bad++; $display("FAIL zf.%0d rt_sel got=%0d want=%0d", i, fwd_rt_sel, e.rt); end
      total++; if (stall_cnt !== e.cnt) begin bad++; $display("FAIL zf.%0d cnt got=%0d want=%0d", i, stall_cnt, e.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ext_stall();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0); push_exp(0, 0, 0, 0); end  // lw r4
        1, 2, 3: begin drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 1); push_exp(1, 0, 0, 0); end
        4: begin drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); push_exp(1, 0, 0, 0); end
        default: begin drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); push_exp(0, 2, 0, 1); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      total++; if (stall !== e.stall) begin bad++; $display("FAIL ext.%0d stall got=%b want=%b", i, stall, e.stall); end
      total++; if (fwd_rs_sel !== e.rs) begin bad++; $display("FAIL ext.%0d rs_sel got=%0d want=%0d", i, fwd_rs_sel, e.rs); end
      total++; if (fwd_rt_sel !== e.rt) begin bad++; $display("FAIL ext.%0d rt_sel got=%0d want=%0d", i, fwd_rt_sel, e.rt); end
      total++; if (stall_cnt !== e.cnt) begin bad++; $display("FAIL ext.%0d cnt got=%0d want=%0d", i, stall_cnt, e.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); push_exp(0, 0, 0, 0); end  // lw r1
        1: begin drive(1, 1, 1, 0, 0, 1, 2, 0, 0, 0); push_exp(1, 0, 0, 0); end  // stall
        2: begin drive(1, 1, 1, 0, 0, 1, 2, 0, 0, 0); push_exp(0, 2, 0, 1); end
        3: begin drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); push_exp(0, 0, 0, 1); end
        4: begin drive(1, 1, 3, 1, 2, 1, 4, 0, 0, 0); push_exp(0, 1, 2, 1); end
        default: begin
          do_reset();
          drive(1, 1, 4, 1, 3, 0, 0, 0, 0, 0);
          push_exp(0, 0, 0, 0);
        end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      total++; if (stall !== e.stall) begin bad++; $display("FAIL rst.%0d stall got=%b want=%b", i, stall, e.stall); end
      total++; if (fwd_rs_sel !== e.rs) begin bad++; $display("FAIL rst.%0d rs_sel got=%0d want=%0d", i, fwd_rs_sel, e.rs); end
      total++; if (fwd_rt_sel !== e.rt) begin bad++; $display("FAIL rst.%0d rt_sel got=%0d want=%0d", i, fwd_rt_sel, e.rt); end
      total++; if (stall_cnt !== e.cnt) begin bad++; $display("FAIL rst.%0d cnt got=%0d want=%0d", i, stall_cnt, e.cnt); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_back_to_back();
    test_zero_and_flush();
    test_ext_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
